// File: rtl/mux_pipe.sv
// mux_pipe: pipelined, back-pressured N:1 radix-4 select tree per lane, one register level per tree level.
// Define MUX_PIPE_SEL_CHECK_EN to add the sticky out-of-range select flag on ERR.
module mux_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_DATA = 16,
  parameter int NUM_LANES = 1,
  localparam int CTRL_WIDTH = (NUM_DATA > 1) ? $clog2(NUM_DATA) : 1,
  localparam int LATENCY = (CTRL_WIDTH + 1) / 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DATA_WIDTH*NUM_DATA-1:0]  DATA_IN,
  input  logic [CTRL_WIDTH*NUM_LANES-1:0] CTRL_IN,
  input  logic                            IN_VALID,
  output logic                            IN_READY,
  output logic [DATA_WIDTH*NUM_LANES-1:0] DATA_OUT,
  output logic                            OUT_VALID,
  input  logic                            OUT_READY,
  output logic                            ERR
);
  localparam int PW = 4 ** LATENCY;
  localparam int SW = 2 * LATENCY;
  logic                         w_en;
  logic [LATENCY-1:0]           r_valid;
  logic [LATENCY:0]             w_v;
  logic [PW*DATA_WIDTH-1:0]     w_pad;
  assign w_en = !OUT_VALID || OUT_READY;
  assign IN_READY = w_en;
  assign w_v = {r_valid, IN_VALID};
  assign OUT_VALID = w_v[LATENCY];
  // Zero padding up to a full 4^LATENCY tree makes every out-of-range select decode to zero.
  assign w_pad = (PW*DATA_WIDTH)'(DATA_IN);
  always_ff @(posedge clk)
    if (reset) r_valid <= '0;
    else if (w_en) r_valid <= w_v[LATENCY-1:0];
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [SW-1:0] w_sel0;
    assign w_sel0 = (NUM_DATA > 1) ? SW'(CTRL_IN[l*CTRL_WIDTH +: CTRL_WIDTH]) : '0;
    for (genvar k = 0; k < LATENCY; k++) begin : g_lvl
      localparam int NO = 4 ** (LATENCY - k - 1);
      localparam int SI = SW - 2 * k;
      logic [4*NO*DATA_WIDTH-1:0] w_in;
      logic [SI-1:0]              w_sel;
      logic [NO*DATA_WIDTH-1:0]   r_out;
      if (k == 0) begin : g_first
        assign w_in = w_pad;
        assign w_sel = w_sel0;
      end else begin : g_next
        assign w_in = g_lvl[k-1].r_out;
        assign w_sel = g_lvl[k-1].g_fwd.r_sel;
      end
      // Data only loads behind a valid word so bubbles leave the held output untouched.
      always_ff @(posedge clk)
        if (reset) r_out <= '0;
        else if (w_en && w_v[k])
          for (int j = 0; j < NO; j++)
            r_out[j*DATA_WIDTH +: DATA_WIDTH] <= w_in[(4*j + int'(w_sel[1:0]))*DATA_WIDTH +: DATA_WIDTH];
      if (SI > 2) begin : g_fwd
        logic [SI-3:0] r_sel;
        always_ff @(posedge clk)
          if (reset) r_sel <= '0;
          else if (w_en && w_v[k]) r_sel <= w_sel[SI-1:2];
      end
    end
    assign DATA_OUT[l*DATA_WIDTH +: DATA_WIDTH] = g_lvl[LATENCY-1].r_out;
  end
`ifdef MUX_PIPE_SEL_CHECK_EN
  logic [NUM_LANES-1:0] w_oor;
  logic                 r_err;
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_chk
    assign w_oor[l] = (NUM_DATA > 1) && (int'(CTRL_IN[l*CTRL_WIDTH +: CTRL_WIDTH]) >= NUM_DATA);
  end
  always_ff @(posedge clk)
    if (reset) r_err <= 1'b0;
    else if (IN_VALID && w_en && |w_oor) r_err <= 1'b1;
  assign ERR = r_err;
`else
  assign ERR = 1'b0;
`endif
endmodule

// File: tb/tb_mux_pipe.sv
// tb_mux_pipe: vector table, scoreboard and corner sequences for mux_pipe at NUM_DATA 16 (2 lanes), 10, 1 and 64.
module tb_mux_pipe;
`ifdef MUX_PIPE_SEL_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif
  logic clk = 0;
  logic reset = 1;
  logic [3:0] iv = '0;
  logic [3:0] ordy = '1;
  wire  [3:0] ir, ov, err;
  logic [255:0]  d16 = '0;
  logic [7:0]    c16 = '0;
  wire  [31:0]   o16;
  logic [159:0]  d10 = '0;
  logic [3:0]    c10 = '0;
  wire  [15:0]   o10;
  logic [15:0]   d1 = '0;
  logic [0:0]    c1 = '0;
  wire  [15:0]   o1;
  logic [1023:0] d64 = '0;
  logic [5:0]    c64 = '0;
  wire  [15:0]   o64;
  int checks = 0;
  int errors = 0;

  mux_pipe #(.DATA_WIDTH(16), .NUM_DATA(16), .NUM_LANES(2)) u16 (
    .clk(clk), .reset(reset), .DATA_IN(d16), .CTRL_IN(c16), .IN_VALID(iv[0]), .IN_READY(ir[0]),
    .DATA_OUT(o16), .OUT_VALID(ov[0]), .OUT_READY(ordy[0]), .ERR(err[0]));
  mux_pipe #(.DATA_WIDTH(16), .NUM_DATA(10), .NUM_LANES(1)) u10 (
    .clk(clk), .reset(reset), .DATA_IN(d10), .CTRL_IN(c10), .IN_VALID(iv[1]), .IN_READY(ir[1]),
    .DATA_OUT(o10), .OUT_VALID(ov[1]), .OUT_READY(ordy[1]), .ERR(err[1]));
  mux_pipe #(.DATA_WIDTH(16), .NUM_DATA(1), .NUM_LANES(1)) u1 (
    .clk(clk), .reset(reset), .DATA_IN(d1), .CTRL_IN(c1), .IN_VALID(iv[2]), .IN_READY(ir[2]),
    .DATA_OUT(o1), .OUT_VALID(ov[2]), .OUT_READY(ordy[2]), .ERR(err[2]));
  mux_pipe #(.DATA_WIDTH(16), .NUM_DATA(64), .NUM_LANES(1)) u64 (
    .clk(clk), .reset(reset), .DATA_IN(d64), .CTRL_IN(c64), .IN_VALID(iv[3]), .IN_READY(ir[3]),
    .DATA_OUT(o64), .OUT_VALID(ov[3]), .OUT_READY(ordy[3]), .ERR(err[3]));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Each lane returns the input word its select names.
  function automatic logic [31:0] model16(input logic [255:0] d, input logic [7:0] c);
    logic [31:0] r;
    for (int l = 0; l < 2; l++) r[l*16 +: 16] = d[c[l*4 +: 4]*16 +: 16];
    return r;
  endfunction

  // Scoreboard for the 16-input, 2-lane instance.
  logic [31:0] q[$];
  logic stall_prev = 0;
  logic [31:0] prev_out = '0;
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      stall_prev = 0;
    end else begin
      chk("in_ready_rule", ir[0], !(ov[0] && !ordy[0]));
      if (stall_prev) begin
        chk("stall_valid_hold", ov[0], 1);
        chk("stall_data_hold", o16, prev_out);
      end
      if (ov[0] && ordy[0]) begin
        chk("sb_expected_item", q.size() > 0, 1);
        if (q.size() > 0) chk("sb_data", o16, q.pop_front());
      end
      if (iv[0] && ir[0]) q.push_back(model16(d16, c16));
      stall_prev = ov[0] && !ordy[0];
      prev_out = o16;
    end
  end

  task automatic pulse_lat(input int idx, input int exp_lat, input string nm);
    int n;
    @(posedge clk); #1; iv[idx] = 1;
    @(posedge clk); #1; iv[idx] = 0;
    n = 1;
    while (!ov[idx] && n < 10) begin
      @(posedge clk); #1; n++;
    end
    chk(nm, n, exp_lat);
  endtask

  task automatic drain();
    iv[0] = 0; ordy[0] = 1;
    repeat (6) @(posedge clk);
    #1;
    chk("drain_empty", q.size(), 0);
  endtask

  typedef struct { logic [3:0] c0, c1; logic [15:0] e0, e1; } vec_t;
  vec_t tv[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sent, n;
    logic [3:0] pat;
    logic [15:0] e64;
    tv = '{'{4'd5, 4'd15, 16'hA005, 16'hA00F}, '{4'd0, 4'd0, 16'hA000, 16'hA000},
           '{4'd15, 4'd0, 16'hA00F, 16'hA000}, '{4'd3, 4'd12, 16'hA003, 16'hA00C},
           '{4'd8, 4'd7, 16'hA008, 16'hA007}, '{4'd10, 4'd1, 16'hA00A, 16'hA001}};
    for (int i = 0; i < 16; i++) d16[i*16 +: 16] = 16'hA000 + 16'(i);
    for (int i = 0; i < 10; i++) d10[i*16 +: 16] = 16'hA000 + 16'(i);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", ov, 4'h0);
    chk("rst_data16", o16, 0);
    chk("rst_err", err, 4'h0);
    chk("rst_in_ready", ir, 4'hF);
    reset = 0;
    // Single-shot table: latency 2, one-cycle valid, per-lane data.
    for (int i = 0; i < 6; i++) begin
      c16 = {tv[i].c1, tv[i].c0};
      pulse_lat(0, 2, "lat16");
      chk("tv_lane0", o16[15:0], tv[i].e0);
      chk("tv_lane1", o16[31:16], tv[i].e1);
      @(posedge clk); #1;
      chk("tv_one_cycle", ov[0], 0);
    end
    // 20 sequential selects while OUT_READY toggles.
    sent = 0; n = 0;
    while (sent < 20 && n < 200) begin
      @(posedge clk); #1; n++;
      ordy[0] = 1'(n % 2);
      iv[0] = 1;
      c16 = {4'(15 - sent % 16), 4'(sent % 16)};
      @(negedge clk);
      if (ir[0]) sent++;
    end
    chk("stream_sent", sent, 20);
    @(posedge clk); #1;
    drain();
    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      @(posedge clk); #1;
      iv[0] = $urandom_range(0, 3) != 0;
      ordy[0] = $urandom_range(0, 2) != 0;
      c16 = 8'($urandom);
      for (int j = 0; j < 8; j++) d16[j*32 +: 32] = $urandom;
    end
    drain();
    // Fill, stall, release.
    @(posedge clk); #1; ordy[0] = 0; iv[0] = 1;
    repeat (7) begin
      @(posedge clk); #1;
      c16 = 8'($urandom);
      for (int j = 0; j < 8; j++) d16[j*32 +: 32] = $urandom;
    end
    chk("stall_in_blocked", ir[0], 0);
    chk("stall_out_valid", ov[0], 1);
    iv[0] = 0; ordy[0] = 1; pat = '0;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      pat[t] = ov[0];
    end
    chk("release_back_to_back", pat, 4'b0011);
    drain();
    // Reset with two items in flight.
    for (int i = 0; i < 16; i++) d16[i*16 +: 16] = 16'hA000 + 16'(i);
    c16 = 8'h21;
    @(posedge clk); #1; iv[0] = 1;
    @(posedge clk); #1;
    @(posedge clk); #1; reset = 1;
    @(posedge clk); #1;
    chk("midrst_valid", ov[0], 0);
    chk("midrst_data", o16, 0);
    chk("midrst_err", err[0], 0);
    chk("midrst_ready", ir[0], 1);
    reset = 0; iv[0] = 0;
    pat = '0;
    for (int t = 0; t < 4; t++) begin
      @(posedge clk); #1;
      pat[t] = ov[0];
    end
    chk("midrst_no_output", pat, 4'b0000);
    // NUM_DATA=10 range handling.
    c10 = 4'd9;
    pulse_lat(1, 2, "lat10");
    chk("n10_in_range", o10, 16'hA009);
    chk("n10_err_clear", err[1], 0);
    c10 = 4'd12;
    @(posedge clk); #1; iv[1] = 1;
    @(posedge clk); #1; iv[1] = 0; c10 = 4'd3;
    chk("n10_err_next", err[1], EXP_ERR);
    @(posedge clk); #1;
    chk("n10_oor_valid", ov[1], 1);
    chk("n10_oor_zero", o10, 16'h0000);
    pulse_lat(1, 2, "lat10b");
    chk("n10_after_oor", o10, 16'hA003);
    chk("n10_err_held", err[1], EXP_ERR);
    // NUM_DATA=1: registered pass-through, select ignored.
    d1 = 16'h1234; c1 = 1'b1;
    pulse_lat(2, 1, "lat1");
    chk("n1_data", o1, 16'h1234);
    d1 = 16'hBEEF; c1 = 1'b0;
    pulse_lat(2, 1, "lat1b");
    chk("n1_data_b", o1, 16'hBEEF);
    // NUM_DATA=64: latency 3.
    for (int t = 0; t < 3; t++) begin
      for (int j = 0; j < 32; j++) d64[j*32 +: 32] = $urandom;
      c64 = 6'($urandom);
      e64 = d64[c64*16 +: 16];
      pulse_lat(3, 3, "lat64");
      chk("n64_data", o64, e64);
    end
    chk("n16_err_never", err[0], 0);
    reset = 1;
    @(posedge clk); #1;
    chk("final_rst_err", err, 4'h0);
    chk("final_rst_valid", ov, 4'h0);
    chk("final_rst_ready", ir, 4'hF);
    chk("final_rst_data10", o10, 0);
    reset = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux_pipe.md
# mux_pipe

Pipelined, back-pressured N:1 selector for the datapath interconnect. It replaces the combinational tri-state mux wherever wide fan-in selection must close timing. It supports several independent output lanes that select from one shared input bus. Selection runs through a radix-4 tree with one register level per tree level, and a valid/ready handshake allows stalls.

## Interface
Parameters:
- DATA_WIDTH, 16, bits per input word
- NUM_DATA, 16, number of input words (1..256)
- NUM_LANES, 1, number of independent output lanes
- CTRL_WIDTH (local), max(1, ceil(log2(NUM_DATA))), per-lane select width
- LATENCY (local), max(1, ceil(log4(NUM_DATA))), register levels

Ports:
- clk, input, 1, single clock; all logic on rising edge
- reset, input, 1, synchronous, active-high reset
- DATA_IN, input, DATA_WIDTH*NUM_DATA, word i at [i*DATA_WIDTH +: DATA_WIDTH]
- CTRL_IN, input, CTRL_WIDTH*NUM_LANES, lane l select at [l*CTRL_WIDTH +: CTRL_WIDTH]
- IN_VALID, input, 1, DATA_IN/CTRL_IN valid
- IN_READY, output, 1, block accepts input this cycle
- DATA_OUT, output, DATA_WIDTH*NUM_LANES, lane l result at [l*DATA_WIDTH +: DATA_WIDTH]
- OUT_VALID, output, 1, DATA_OUT valid
- OUT_READY, input, 1, downstream accepts
- ERR, output, 1, sticky out-of-range select flag (see Configuration)

## Operation
- Each lane is a radix-4 tree. Level k resolves select bits [2k+1:2k] and registers the surviving words plus the remaining upper select bits.
- The last level may be radix-2 if CTRL_WIDTH is odd.
- For NUM_DATA=1: DATA_OUT = DATA_IN registered once; CTRL_IN is ignored.
- Select value ≥ NUM_DATA (out of range): that lane outputs all-zero data. No X and no Z. Tri-state is forbidden internally.
- A valid bit accompanies every level. All levels share one enable: en = !OUT_VALID | OUT_READY.
- IN_READY = en (combinational from OUT_VALID and OUT_READY).
- Transfer in: IN_VALID & IN_READY. Transfer out: OUT_VALID & OUT_READY.
- When en=1, every level advances. A level loads valid=0 if its source valid is 0, so bubbles collapse only at the output stall point.
- When en=0, all levels hold data and valid. DATA_OUT and OUT_VALID stay stable until accepted.
- Lanes are independent in data and share handshake and valid.

## Timing
- Latency: LATENCY cycles from an accepted input to OUT_VALID with no stall. NUM_DATA=16 gives 2; 64 gives 3; 4 gives 1.
- Throughput: one transfer per cycle while OUT_READY=1.
- Reset (synchronous, clk edge with reset=1):
  - all valid bits are cleared, so OUT_VALID=0
  - DATA_OUT=0 and ERR=0
  - IN_READY=1 in the first cycle after reset
- Reset mid-operation: in-flight data is discarded with no partial output. Reset dominates IN_VALID in the same cycle.
- If input and output transfer in the same cycle with a full pipe, both succeed. Occupancy stays LATENCY.
- If OUT_READY falls while the pipe is full, input is blocked in that same cycle (IN_READY=0). No data is lost or duplicated.
- A change of CTRL_IN while IN_VALID=0 has no effect.

## Configuration
- Macro: MUX_PIPE_SEL_CHECK_EN.
- Defined:
  - An out-of-range select on any lane in an accepted input sets ERR on the cycle after acceptance.
  - ERR stays 1 until reset.
  - Out-of-range data is zero.
- Undefined:
  - No range-check logic; ERR is tied to 0.
  - Out-of-range select still yields zero data, through a decode default.
  - Latency and handshake are identical.

## Test plan
- NUM_DATA=16, NUM_LANES=2, DATA_IN word i = 16'hA000+i. CTRL lane0=5, lane1=15, IN_VALID=1 for one cycle, OUT_READY=1 -> after 2 cycles OUT_VALID=1 for one cycle; DATA_OUT lane0=16'hA005, lane1=16'hA00F.
- Stream 20 inputs with sequential selects 0..15,0..3 while OUT_READY toggles 1,0 -> output order and values match a scoreboard; no loss or duplication. IN_READY=0 exactly when OUT_VALID=1 & OUT_READY=0.
- NUM_DATA=10, select 12 with the macro defined -> DATA_OUT lane=0 and ERR=1 the cycle after acceptance, held until reset. With the macro undefined -> DATA_OUT=0 and ERR=0.
- Fill the pipe and hold OUT_READY=0 for 5 cycles -> DATA_OUT and OUT_VALID stable. Release -> the queued items emerge in back-to-back cycles.
- Assert reset with 2 items in flight -> next cycle OUT_VALID=0, DATA_OUT=0, ERR=0, IN_READY=1. The items are never output.
- NUM_DATA=1, DATA_IN=16'h1234 -> OUT_VALID one cycle after acceptance with DATA_OUT=16'h1234. NUM_DATA=64 -> latency 3.
